// File: rtl/switch_debouncer_if.sv
// Switch debouncer signal bundle: the raw switch input and the cleaned level and pulses.
// The master drives the switch; the slave (the debouncer) returns the filtered view.
interface switch_debouncer_if;
  logic sw_in;
  logic sw_level;
  logic press_pulse;
  logic release_pulse;
  logic step_pulse;

  modport master (
    output sw_in,
    input  sw_level,
    input  press_pulse,
    input  release_pulse,
    input  step_pulse
  );

  modport slave (
    input  sw_in,
    output sw_level,
    output press_pulse,
    output release_pulse,
    output step_pulse
  );
endinterface

// File: rtl/switch_debouncer.sv
// Push-button front-end: 2-FF synchroniser, tick-sampled stability filter and registered
// press/release/step pulses, with auto-repeat on step while the button stays held.
module switch_debouncer #(
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 8,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_debouncer_if.slave sw
);
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STAB_W  = $clog2(STABLE_CNT + 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
  localparam logic [REP_W-1:0]  DLY_LAST  = REP_W'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
  localparam logic [REP_W-1:0]  PER_LAST  = REP_W'((REPEAT_PER > 0) ? REPEAT_PER - 1 : 0);
  localparam logic              RELEASED  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        sync_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
  logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
  logic              first_done_reg, first_done_next;
  logic              level_reg, level_next;
  logic              press_reg, press_next;
  logic              release_reg, release_next;
  logic              step_reg, step_next;
  logic              s;
  logic              tick;
  logic              do_press;
  logic              do_release;

  // Synchroniser resets to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {2{RELEASED}};
    end else begin
      sync_reg <= {sync_reg[0], sw.sw_in};
    end
  end

  assign s = sync_reg[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      stab_cnt_reg   <= '0;
      rep_cnt_reg    <= '0;
      first_done_reg <= 1'b0;
      level_reg      <= 1'b0;
      press_reg      <= 1'b0;
      release_reg    <= 1'b0;
      step_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stab_cnt_reg   <= stab_cnt_next;
      rep_cnt_reg    <= rep_cnt_next;
      first_done_reg <= first_done_next;
      level_reg      <= level_next;
      press_reg      <= press_next;
      release_reg    <= release_next;
      step_reg       <= step_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    stab_cnt_next   = stab_cnt_reg;
    rep_cnt_next    = rep_cnt_reg;
    first_done_next = first_done_reg;
    level_next      = level_reg;
    press_next      = 1'b0;
    release_next    = 1'b0;
    step_next       = 1'b0;
    do_press        = 1'b0;
    do_release      = 1'b0;

    if (tick) begin
      unique case (state_reg)
        IDLE: begin
          if (s) begin
            if (STABLE_CNT == 1) begin
              do_press = 1'b1;
            end else begin
              state_next    = PRESS_CHK;
              stab_cnt_next = STAB_W'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_next    = IDLE;
            stab_cnt_next = '0;
          end else if (stab_cnt_reg == STAB_LAST) begin
            do_press = 1'b1;
          end else begin
            stab_cnt_next = stab_cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            if (STABLE_CNT == 1) begin
              do_release = 1'b1;
            end else begin
              state_next    = RELEASE_CHK;
              stab_cnt_next = STAB_W'(1);
            end
          end else if (REPEAT_DLY > 0) begin
            if (!first_done_reg && rep_cnt_reg == DLY_LAST) begin
              step_next       = 1'b1;
              rep_cnt_next    = '0;
              first_done_next = 1'b1;
            end else if (first_done_reg && rep_cnt_reg == PER_LAST) begin
              step_next    = 1'b1;
              rep_cnt_next = '0;
            end else begin
              rep_cnt_next = rep_cnt_reg + 1'b1;
            end
          end
        end
        RELEASE_CHK: begin
          // A bounce back to pressed resumes the repeat schedule where it was frozen.
          if (s) begin
            state_next    = HELD;
            stab_cnt_next = '0;
          end else if (stab_cnt_reg == STAB_LAST) begin
            do_release = 1'b1;
          end else begin
            stab_cnt_next = stab_cnt_reg + 1'b1;
          end
        end
      endcase
    end

    if (do_press) begin
      state_next      = HELD;
      stab_cnt_next   = '0;
      rep_cnt_next    = '0;
      first_done_next = 1'b0;
      level_next      = 1'b1;
      press_next      = 1'b1;
      step_next       = 1'b1;
    end

    if (do_release) begin
      state_next    = IDLE;
      stab_cnt_next = '0;
      level_next    = 1'b0;
      release_next  = 1'b1;
    end
  end

  assign sw.sw_level      = level_reg;
  assign sw.press_pulse   = press_reg;
  assign sw.release_pulse = release_reg;
  assign sw.step_pulse    = step_reg;
endmodule
